// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one iterative divider among NREQ requesters
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_dividend,
  input  logic [NREQ*WIDTH-1:0]   req_divisor,
  output logic [NREQ-1:0]         ack,
  output logic                    res_valid,
  output logic [2:0]              res_id,
  output logic [WIDTH-1:0]        res_quot,
  output logic [WIDTH-1:0]        res_rem,
  output logic                    res_div0,
  output logic                    res_err,
  output logic                    busy,
  output logic                    div_start,
  output logic [WIDTH-1:0]        div_dividend,
  output logic [WIDTH-1:0]        div_divisor,
  input  logic                    div_done,
  input  logic [WIDTH-1:0]        div_quot,
  input  logic [WIDTH-1:0]        div_rem
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nx;
  logic [2:0]        rr_ptr;
  logic [2:0]        cur_id;
  logic [2:0]        win_id;
  logic              win_found;
  logic [15:0]       wdog;
  logic              wdog_hit;
  logic [WIDTH-1:0]  sel_dvd;
  logic [WIDTH-1:0]  sel_dvs;
  logic [NREQ-1:0]   req_sh;
  int                j;

  // Search upward from the round-robin pointer, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = 3'd0;
    req_sh    = '0;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      req_sh = req >> j;
      if (!win_found && req_sh[0]) begin
        win_found = 1'b1;
        win_id    = 3'(j);
      end
    end
  end

  assign sel_dvd  = WIDTH'(req_dividend >> (int'(win_id) * WIDTH));
  assign sel_dvs  = WIDTH'(req_divisor  >> (int'(win_id) * WIDTH));
  assign wdog_hit = (wdog + 16'd1) == 16'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (win_found) state_nx = (sel_dvs == '0) ? S_RESP : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (div_done || wdog_hit) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Result registers load on the edge that enters RESP and hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      cur_id       <= '0;
      wdog         <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      res_id       <= '0;
      res_quot     <= '0;
      res_rem      <= '0;
      res_div0     <= 1'b0;
      res_err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            cur_id       <= win_id;
            div_dividend <= sel_dvd;
            div_divisor  <= sel_dvs;
            if (sel_dvs == '0) begin
              res_id   <= win_id;
              res_quot <= '1;
              res_rem  <= sel_dvd;
              res_div0 <= 1'b1;
              res_err  <= 1'b0;
            end
          end
        end
        S_ISSUE: wdog <= '0;
        S_WAIT: begin
          if (div_done) begin
            res_id   <= cur_id;
            res_quot <= div_quot;
            res_rem  <= div_rem;
            res_div0 <= 1'b0;
            res_err  <= 1'b0;
          end else begin
            wdog <= wdog + 16'd1;
            if (wdog_hit) begin
              res_id   <= cur_id;
              res_quot <= '0;
              res_rem  <= '0;
              res_div0 <= 1'b0;
              res_err  <= 1'b1;
            end
          end
        end
        S_RESP: rr_ptr <= (res_id == 3'(NREQ - 1)) ? 3'd0 : res_id + 3'd1;
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign div_start = (state == S_ISSUE);
  assign res_valid = (state == S_RESP);
  assign ack       = res_valid ? ({{(NREQ-1){1'b0}}, 1'b1} << res_id) : '0;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - scoreboard bench for div_arbiter with a behavioural divider core
module tb_div_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*W-1:0] req_dividend = '0;
  logic [NREQ*W-1:0] req_divisor  = '0;
  logic [NREQ-1:0]   ack;
  logic              res_valid, res_div0, res_err, busy, div_start, div_done;
  logic [2:0]        res_id;
  logic [W-1:0]      res_quot, res_rem, div_dividend, div_divisor;
  logic [W-1:0]      div_quot = '0, div_rem = '0;
  logic              model_done = 1'b0, stray_done = 1'b0, core_en = 1'b1;

  typedef struct {
    logic [2:0] id;
    logic [7:0] q;
    logic [7:0] r;
    logic       d0;
    logic       er;
  } exp_t;

  exp_t       q_exp[$];
  exp_t       e;
  int         vectors = 0, miscompares = 0, start_cnt = 0, cnt = 0;
  logic [7:0] lat_a, lat_b;
  int         rem_jobs[NREQ];
  logic [7:0] nxt_a[NREQ], nxt_b[NREQ];

  assign div_done = model_done | stray_done;

  div_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .ack(ack), .res_valid(res_valid), .res_id(res_id), .res_quot(res_quot), .res_rem(res_rem),
    .res_div0(res_div0), .res_err(res_err), .busy(busy), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int id, input logic [7:0] a, input logic [7:0] b, input int mode);
    exp_t x;
    x.id = 3'(id);
    case (mode)
      1:       begin x.q = 8'hFF;  x.r = a;     x.d0 = 1'b1; x.er = 1'b0; end
      2:       begin x.q = 8'h00;  x.r = 8'h00; x.d0 = 1'b0; x.er = 1'b1; end
      default: begin x.q = a / b;  x.r = a % b; x.d0 = 1'b0; x.er = 1'b0; end
    endcase
    q_exp.push_back(x);
  endfunction

  // Divider core: done pulses five cycles after the start cycle unless core_en is low.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (rst) begin
      cnt = 0;
    end else if (div_start) begin
      cnt = 5; lat_a = div_dividend; lat_b = div_divisor;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && core_en) begin
        model_done = 1'b1; div_quot = lat_a / lat_b; div_rem = lat_a % lat_b;
      end
    end
  end

  always @(negedge clk) begin
    if (div_start) start_cnt++;
    if (!rst && (res_valid || ack != '0)) begin
      if (q_exp.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'(0));
      end else begin
        e = q_exp.pop_front();
        check("res_valid", 32'(res_valid), 32'(1));
        check("ack_onehot", 32'(ack), 32'(1) << e.id);
        check("res_id", 32'(res_id), 32'(e.id));
        check("res_quot", 32'(res_quot), 32'(e.q));
        check("res_rem", 32'(res_rem), 32'(e.r));
        check("res_div0", 32'(res_div0), 32'(e.d0));
        check("res_err", 32'(res_err), 32'(e.er));
      end
    end
  end

  task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
    req_dividend[id*W +: W] = a;
    req_divisor[id*W +: W]  = b;
  endtask

  task automatic job(input int id, input logic [7:0] a, input logic [7:0] b, input int mode);
    int n;
    @(negedge clk);
    check("idle_before_job", 32'(busy), 32'(0));
    set_ops(id, a, b);
    req[id] = 1'b1;
    push_exp(id, a, b, mode);
    @(negedge clk);
    if (mode == 1) begin
      check("div0_ack_t1", 32'(ack[id]), 32'(1));
      check("div0_no_start", 32'(div_start), 32'(0));
    end else begin
      check("start_at_t1", 32'(div_start), 32'(1));
      n = 0;
      while (ack[id] == 1'b0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("ack_latency", 32'(n), (mode == 2) ? 32'(11) : 32'(6));
    end
    req[id] = 1'b0;
  endtask

  task automatic serve(input int n);
    int got, t;
    got = 0; t = 0;
    while (got < n && t < 300) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          got++;
          rem_jobs[i]--;
          if (rem_jobs[i] <= 0) req[i] = 1'b0;
          else set_ops(i, nxt_a[i], nxt_b[i]);
        end
      end
    end
    check("serve_count", 32'(got), 32'(n));
  endtask

  initial begin
    int s0;
    logic [7:0] ca[5];
    logic [7:0] cb[5];
    ca[0] = 8'd200; cb[0] = 8'd9;
    ca[1] = 8'd77;  cb[1] = 8'd5;
    ca[2] = 8'd255; cb[2] = 8'd16;
    ca[3] = 8'd9;   cb[3] = 8'd10;
    ca[4] = 8'd128; cb[4] = 8'd3;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_start", 32'(div_start), 32'(0));
    check("rst_res", {res_quot, res_rem, 5'(res_id), res_div0, res_err, res_valid}, 32'(0));
    check("rst_ops", 32'({div_dividend, div_divisor}), 32'(0));
    rst = 1'b0;

    job(1, 8'd100, 8'd7, 0);
    s0 = start_cnt;
    job(3, 8'd55, 8'd0, 1);
    check("div0_start_cnt", 32'(start_cnt), 32'(s0));

    // Contention: all four request; requester 0 comes back for a second job.
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      set_ops(i, ca[i], cb[i]);
      rem_jobs[i] = 1;
      push_exp(i, ca[i], cb[i], 0);
    end
    rem_jobs[0] = 2; nxt_a[0] = ca[4]; nxt_b[0] = cb[4];
    push_exp(0, ca[4], cb[4], 0);
    req = 4'b1111;
    serve(5);

    // Pointer now 1; serve requester 1 to move it to 2, then 0 must beat 1.
    job(1, 8'd60, 8'd7, 0);
    @(negedge clk);
    set_ops(0, 8'd90, 8'd4); set_ops(1, 8'd33, 8'd11);
    rem_jobs[0] = 1; rem_jobs[1] = 1;
    push_exp(0, 8'd90, 8'd4, 0); push_exp(1, 8'd33, 8'd11, 0);
    req = 4'b0011;
    serve(2);

    core_en = 1'b0;
    job(2, 8'd123, 8'd4, 2);
    core_en = 1'b1;
    job(3, 8'd250, 8'd17, 0);

    // Withdrawn request from requester 2 while requester 0 is in flight.
    @(negedge clk);
    set_ops(0, 8'd45, 8'd6); req[0] = 1'b1; push_exp(0, 8'd45, 8'd6, 0);
    @(negedge clk);
    check("wd_start", 32'(div_start), 32'(1));
    set_ops(2, 8'd1, 8'd1); req[2] = 1'b1;
    repeat (2) @(negedge clk);
    req[2] = 1'b0;
    s0 = 0;
    while (ack[0] == 1'b0 && s0 < 40) begin @(negedge clk); s0++; end
    check("wd_ack0", 32'(ack[0]), 32'(1));
    req[0] = 1'b0;

    // Stray done while idle.
    repeat (2) @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check("stray_busy", 32'(busy), 32'(0));
    check("stray_ack", 32'(ack), 32'(0));

    // Reset mid-WAIT, after requester 1 leaves the pointer at 2.
    job(1, 8'd20, 8'd3, 0);
    @(negedge clk);
    set_ops(2, 8'd99, 8'd9); req[2] = 1'b1; push_exp(2, 8'd99, 8'd9, 0);
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    void'(q_exp.pop_back());
    req[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_ack", 32'(ack), 32'(0));
    check("rst_mid_ops", 32'({div_dividend, div_divisor}), 32'(0));
    check("rst_mid_res", {res_quot, res_rem, 5'(res_id), res_div0, res_err, res_valid}, 32'(0));
    set_ops(1, 8'd81, 8'd9); set_ops(3, 8'd70, 8'd8);
    rem_jobs[1] = 1; rem_jobs[3] = 1;
    push_exp(1, 8'd81, 8'd9, 0); push_exp(3, 8'd70, 8'd8, 0);
    req = 4'b1010;
    serve(2);

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(q_exp.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
